// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared types and constants for the UART TX scheduler.
// Holds the FSM state enum, UART register offsets and status bit index.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POLL_REQ  = 3'd1,
    S_POLL_WAIT = 3'd2,
    S_WR_REQ    = 3'd3,
    S_WR_WAIT   = 3'd4
  } state_e;

  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;

  localparam int unsigned STATUS_TX_IDLE = 5;

  function automatic logic [31:0] reg_addr(
    input logic [31:0] base,
    input logic [7:0]  off
  );
    return base + {24'h0, off};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr.sv
// rr_arbiter: rotating-priority arbiter for the UART TX scheduler.
// Priority starts at ptr; on advance, ptr moves just past the winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic                 advance_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] ptr_o
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Grant the first requester at or after the pointer.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[wrap(int'(ptr_q) + k)]) begin
        found = 1'b1;
        grant_o[wrap(int'(ptr_q) + k)] = 1'b1;
        ptr_d = PW'(wrap(int'(ptr_q) + k + 1));
      end
    end
  end

  // Pointer register; requester 0 is highest priority after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: arbitrates byte requesters, polls UART status, writes.
// Optional poll timeout enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter logic [31:0] UART_BASE  = 32'h1000_0000,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  input  logic                 wb_ack_i,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_we_o,
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam int PW = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic                gap_q, gap_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic [NUM_REQ-1:0]  grant;
  logic [PW-1:0]       rr_ptr;
  logic                advance;
  logic                tx_idle;
  logic                poll_busy;
  logic                give_up;
  logic [7:0]          gbyte;

  assign advance   = (state_q == S_IDLE) && (|req_valid_i);
  assign tx_idle   = wb_dat_i[STATUS_TX_IDLE];
  assign poll_busy = (state_q == S_POLL_WAIT) && wb_ack_i && !tx_idle;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .advance_i (advance),
    .grant_o   (grant),
    .ptr_o     (rr_ptr)
  );

  // Select the byte of the granted requester.
  always_comb begin
    gbyte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gbyte = req_data_i[8*i +: 8];
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(POLL_LIMIT + 1);

  logic [CW-1:0] poll_cnt_q;

  // Count not-idle status replies for the byte in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      poll_cnt_q <= '0;
    end else if (advance) begin
      poll_cnt_q <= '0;
    end else if (poll_busy) begin
      poll_cnt_q <= poll_cnt_q + 1'b1;
    end
  end

  assign give_up = poll_busy && (poll_cnt_q == CW'(POLL_LIMIT - 1));
`else
  assign give_up = 1'b0;
`endif

  // Next-state and bus register updates.
  always_comb begin
    state_d = state_q;
    gap_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (advance) begin
          state_d = S_POLL_REQ;
          adr_d   = reg_addr(UART_BASE, REG_STATUS);
          dat_d   = {24'h0, gbyte};
          sel_d   = 4'b0001;
        end
      end
      S_POLL_REQ: begin
        state_d = gap_q ? S_POLL_REQ : S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (wb_ack_i) begin
          if (tx_idle) begin
            state_d = S_WR_REQ;
            adr_d   = reg_addr(UART_BASE, REG_DATA);
          end else if (give_up) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_POLL_REQ;
            gap_d   = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (wb_ack_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and bus registers; reset drops any byte in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign wb_cyc_o    = busy_o && !gap_q;
  assign wb_stb_o    = wb_cyc_o;
  assign wb_we_o     = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign req_ready_o = advance ? grant : '0;
  assign drop_o      = give_up;

endmodule
